evm_booth_arbiter: RTL and testbench

EVM_BOOTH_ARBITER -- requirements
Module: evm_booth_arbiter

---
 rtl/evm_booth_arbiter.sv | 163 ++++++++++++++++
 tb/tb_evm_booth_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_booth_arbiter.sv
// Round-robin arbiter that lets four voting booths share one tally datapath.
// It offers one vote at a time, waits a bounded time for the ack, and then locks the booth.
module evm_booth_arbiter #(
    parameter int NUM_BOOTHS  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    session_open,
    input  logic                    session_close,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [2*NUM_BOOTHS-1:0] booth_choice,
    input  logic [NUM_BOOTHS-1:0]   booth_rearm,
    input  logic                    tally_ack,
    output logic                    tally_valid,
    output logic [1:0]              tally_candidate,
    output logic [1:0]              tally_booth,
    output logic [NUM_BOOTHS-1:0]   booth_grant,
    output logic [NUM_BOOTHS-1:0]   booth_locked,
    output logic [1:0]              state,
    output logic                    timeout_err
);

    localparam int unsigned NB = NUM_BOOTHS;
    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_BUSY   = 2'd2,
        ST_CLOSED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [1:0]          booth_q, booth_d;
    logic [1:0]          cand_q, cand_d;
    logic [NB-1:0]       grant_q, grant_d;
    logic [NB-1:0]       locked_q, locked_d;
    logic                terr_q, terr_d;
    logic [1:0]          rr_q, rr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pend_q, pend_d;

    logic [NB-1:0]       eligible;
    logic                pick_found;
    logic [1:0]          pick_idx;
    logic [1:0]          scan_idx;
    logic                close_now;

    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            eligible[i] = booth_req[i] && !locked_q[i] && (booth_choice[2*i +: 2] != 2'b11);
        end
    end

    // Scan from rr_q upward with 2-bit wrap; the first eligible booth wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            scan_idx = rr_q + k[1:0];
            if (!pick_found && eligible[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        booth_d   = booth_q;
        cand_d    = cand_q;
        grant_d   = '0;
        locked_d  = locked_q & ~booth_rearm;
        terr_d    = terr_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        close_now = pend_q | session_close;

        unique case (state_q)
            ST_IDLE, ST_CLOSED: begin
                if (session_open && !session_close) begin
                    state_d  = ST_OPEN;
                    locked_d = '0;
                    terr_d   = 1'b0;
                    rr_d     = '0;
                end
            end
            ST_OPEN: begin
                if (session_close) begin
                    state_d = ST_CLOSED;
                end else if (pick_found) begin
                    state_d = ST_BUSY;
                    valid_d = 1'b1;
                    booth_d = pick_idx;
                    cand_d  = booth_choice[{pick_idx, 1'b0} +: 2];
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                // Lock is set after the rearm mask, so it wins for the same booth.
                if (tally_ack) begin
                    valid_d           = 1'b0;
                    grant_d[booth_q]  = 1'b1;
                    locked_d[booth_q] = 1'b1;
                    rr_d              = booth_q + 2'd1;
                    state_d           = close_now ? ST_CLOSED : ST_OPEN;
                    pend_d            = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b0;
                    terr_d  = 1'b1;
                    state_d = close_now ? ST_CLOSED : ST_OPEN;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    pend_d = close_now;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            booth_q  <= '0;
            cand_q   <= '0;
            grant_q  <= '0;
            locked_q <= '0;
            terr_q   <= 1'b0;
            rr_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            booth_q  <= booth_d;
            cand_q   <= cand_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
            terr_q   <= terr_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    assign tally_valid     = valid_q;
    assign tally_candidate = cand_q;
    assign tally_booth     = booth_q;
    assign booth_grant     = grant_q;
    assign booth_locked    = locked_q;
    assign state           = state_q;
    assign timeout_err     = terr_q;

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// Self-checking bench for evm_booth_arbiter: a vector table, directed corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_evm_booth_arbiter;

    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       session_open = 1'b0;
    logic       session_close = 1'b0;
    logic [3:0] booth_req = '0;
    logic [7:0] booth_choice = '0;
    logic [3:0] booth_rearm = '0;
    logic       tally_ack = 1'b0;
    logic       tally_valid;
    logic [1:0] tally_candidate;
    logic [1:0] tally_booth;
    logic [3:0] booth_grant;
    logic [3:0] booth_locked;
    logic [1:0] state;
    logic       timeout_err;

    always #5 clk = ~clk;

    evm_booth_arbiter #(.NUM_BOOTHS(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .session_open(session_open), .session_close(session_close),
        .booth_req(booth_req), .booth_choice(booth_choice), .booth_rearm(booth_rearm),
        .tally_ack(tally_ack), .tally_valid(tally_valid), .tally_candidate(tally_candidate),
        .tally_booth(tally_booth), .booth_grant(booth_grant), .booth_locked(booth_locked),
        .state(state), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: session state 0..3, busy age counted in elapsed cycles.
    int     m_state = 0;
    bit     m_valid = 0;
    int     m_booth = 0;
    int     m_cand = 0;
    bit [3:0] m_grant = '0;
    bit [3:0] m_locked = '0;
    bit     m_terr = 0;
    int     m_rr = 0;
    int     m_waited = 0;
    bit     m_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  pick;
        int  b;
        bit  pend_now;
        m_grant = '0;
        if (rst) begin
            m_state = 0; m_valid = 0; m_booth = 0; m_cand = 0; m_locked = '0;
            m_terr = 0; m_rr = 0; m_waited = 0; m_pend = 0;
            return;
        end
        pick = -1;
        for (int k = 0; k < 4; k++) begin
            b = (m_rr + k) % 4;
            if (pick < 0 && booth_req[b] && !m_locked[b] && booth_choice[2*b +: 2] != 2'b11)
                pick = b;
        end
        m_locked = m_locked & ~booth_rearm;
        case (m_state)
            0, 3: begin
                if (session_open && !session_close) begin
                    m_state = 1; m_locked = '0; m_terr = 0; m_rr = 0;
                end
            end
            1: begin
                if (session_close) m_state = 3;
                else if (pick >= 0) begin
                    m_state = 2; m_valid = 1; m_booth = pick;
                    m_cand = int'(booth_choice[2*pick +: 2]); m_waited = 0;
                end
            end
            default: begin
                pend_now = m_pend || session_close;
                m_waited++;
                if (tally_ack) begin
                    m_valid = 0; m_grant[m_booth] = 1'b1; m_locked[m_booth] = 1'b1;
                    m_rr = (m_booth + 1) % 4; m_state = pend_now ? 3 : 1; m_pend = 0;
                end else if (m_waited >= ACK_TIMEOUT) begin
                    m_valid = 0; m_terr = 1; m_state = pend_now ? 3 : 1; m_pend = 0;
                end else begin
                    m_pend = pend_now;
                end
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic o, input logic c, input logic a,
                         input logic [3:0] rq, input logic [3:0] ra, input logic [7:0] ch);
        rst = r; session_open = o; session_close = c; tally_ack = a;
        booth_req = rq; booth_rearm = ra; booth_choice = ch;
    endtask

    typedef struct {
        logic       rst, open, close, ack;
        logic [3:0] req, rearm;
        logic [7:0] choice;
        logic [1:0] e_state;
        logic       e_valid;
        logic [1:0] e_booth, e_cand;
        logic [3:0] e_grant, e_locked;
        logic       e_terr;
    } vec_t;

    function automatic vec_t mk(logic r, logic o, logic c, logic a, logic [3:0] rq, logic [3:0] ra,
                                logic [7:0] ch, logic [1:0] st, logic v, logic [1:0] bo,
                                logic [1:0] ca, logic [3:0] g, logic [3:0] l, logic t);
        vec_t x;
        x.rst = r; x.open = o; x.close = c; x.ack = a; x.req = rq; x.rearm = ra; x.choice = ch;
        x.e_state = st; x.e_valid = v; x.e_booth = bo; x.e_cand = ca;
        x.e_grant = g; x.e_locked = l; x.e_terr = t;
        return x;
    endfunction

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk(1,0,0,0, 4'h0,4'h0,8'h00, 2'd0,0,2'd0,2'd0,4'h0,4'h0,0);
        vecs[1]  = mk(0,1,0,0, 4'h0,4'h0,8'h00, 2'd1,0,2'd0,2'd0,4'h0,4'h0,0);
        vecs[2]  = mk(0,0,0,0, 4'h4,4'h0,8'h10, 2'd2,1,2'd2,2'd1,4'h0,4'h0,0);
        vecs[3]  = mk(0,0,0,0, 4'h4,4'h0,8'h10, 2'd2,1,2'd2,2'd1,4'h0,4'h0,0);
        vecs[4]  = mk(0,0,0,0, 4'h0,4'h0,8'hFF, 2'd2,1,2'd2,2'd1,4'h0,4'h0,0);
        vecs[5]  = mk(0,0,0,1, 4'h0,4'h0,8'h00, 2'd1,0,2'd0,2'd0,4'h4,4'h4,0);
        vecs[6]  = mk(0,0,0,0, 4'h4,4'h0,8'h10, 2'd1,0,2'd0,2'd0,4'h0,4'h4,0);
        vecs[7]  = mk(0,0,0,0, 4'h4,4'h4,8'h10, 2'd1,0,2'd0,2'd0,4'h0,4'h0,0);
        vecs[8]  = mk(0,0,0,0, 4'h8,4'h0,8'hC0, 2'd1,0,2'd0,2'd0,4'h0,4'h0,0);
        vecs[9]  = mk(0,0,0,1, 4'h8,4'h0,8'hC0, 2'd1,0,2'd0,2'd0,4'h0,4'h0,0);
        vecs[10] = mk(0,0,0,0, 4'hC,4'h0,8'hD0, 2'd2,1,2'd2,2'd1,4'h0,4'h0,0);
        vecs[11] = mk(1,0,0,0, 4'hC,4'h0,8'hD0, 2'd0,0,2'd0,2'd0,4'h0,4'h0,0);
        vecs[12] = mk(0,0,0,1, 4'h2,4'h0,8'h00, 2'd0,0,2'd0,2'd0,4'h0,4'h0,0);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].open, vecs[i].close, vecs[i].ack,
                  vecs[i].req, vecs[i].rearm, vecs[i].choice);
            cyc();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d_valid", i), 32'(tally_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_grant", i), 32'(booth_grant), 32'(vecs[i].e_grant));
            chk($sformatf("vec%0d_locked", i), 32'(booth_locked), 32'(vecs[i].e_locked));
            chk($sformatf("vec%0d_terr", i), 32'(timeout_err), 32'(vecs[i].e_terr));
            if (vecs[i].e_valid || vecs[i].rst) begin
                chk($sformatf("vec%0d_booth", i), 32'(tally_booth), 32'(vecs[i].e_booth));
                chk($sformatf("vec%0d_cand", i), 32'(tally_candidate), 32'(vecs[i].e_cand));
            end
        end

        // All four booths request; each ack is immediate, so grants go 0,1,2,3.
        drive(1,0,0,0, 4'h0,4'h0,8'h00); cyc();
        drive(0,1,0,0, 4'h0,4'h0,8'h00); cyc();
        for (int i = 0; i < 4; i++) begin
            drive(0,0,0,0, 4'hF,4'h0,8'h00); cyc();
            chk($sformatf("rr%0d_booth", i), 32'(tally_booth), 32'(i));
            chk($sformatf("rr%0d_valid", i), 32'(tally_valid), 32'd1);
            drive(0,0,0,1, 4'hF,4'h0,8'h00); cyc();
            chk($sformatf("rr%0d_grant", i), 32'(booth_grant), 32'(1 << i));
            chk($sformatf("rr%0d_locked", i), 32'(booth_locked), 32'((1 << (i + 1)) - 1));
            chk($sformatf("rr%0d_state", i), 32'(state), 32'd1);
        end
        drive(0,0,0,0, 4'hF,4'h0,8'h00); cyc();
        chk("rr_all_locked_valid", 32'(tally_valid), 32'd0);
        drive(0,0,0,0, 4'hF,4'h2,8'h00); cyc();
        chk("rr_rearm_locked", 32'(booth_locked), 32'hD);
        drive(0,0,0,0, 4'hF,4'h0,8'h00); cyc();
        chk("rr_rearm_booth", 32'(tally_booth), 32'd1);
        chk("rr_rearm_valid", 32'(tally_valid), 32'd1);
        drive(0,0,0,1, 4'h0,4'h0,8'h00); cyc();
        chk("rr_rearm_grant", 32'(booth_grant), 32'h2);

        // Booth 1 never acked: valid for ACK_TIMEOUT cycles, then timeout and re-offer.
        drive(1,0,0,0, 4'h0,4'h0,8'h00); cyc();
        drive(0,1,0,0, 4'h0,4'h0,8'h00); cyc();
        drive(0,0,0,0, 4'h2,4'h0,8'h08); cyc();
        chk("to_first_valid", 32'(tally_valid), 32'd1);
        chk("to_first_cand", 32'(tally_candidate), 32'd2);
        for (int j = 1; j < ACK_TIMEOUT; j++) begin
            cyc();
            chk($sformatf("to_hold%0d", j), 32'(tally_valid), 32'd1);
        end
        cyc();
        chk("to_drop_valid", 32'(tally_valid), 32'd0);
        chk("to_terr", 32'(timeout_err), 32'd1);
        chk("to_not_locked", 32'(booth_locked), 32'd0);
        chk("to_no_grant", 32'(booth_grant), 32'd0);
        chk("to_state", 32'(state), 32'd1);
        cyc();
        chk("to_reoffer_valid", 32'(tally_valid), 32'd1);
        chk("to_reoffer_booth", 32'(tally_booth), 32'd1);
        drive(0,0,0,1, 4'h0,4'h0,8'h00); cyc();
        chk("to_reoffer_grant", 32'(booth_grant), 32'h2);
        chk("to_terr_sticky", 32'(timeout_err), 32'd1);

        // Close during BUSY: the vote still completes, then the session is CLOSED.
        drive(1,0,0,0, 4'h0,4'h0,8'h00); cyc();
        drive(0,1,0,0, 4'h0,4'h0,8'h00); cyc();
        drive(0,0,0,0, 4'h1,4'h0,8'h01); cyc();
        chk("cl_busy", 32'(state), 32'd2);
        drive(0,0,1,0, 4'h0,4'h0,8'h00); cyc();
        chk("cl_still_busy", 32'(state), 32'd2);
        drive(0,0,0,0, 4'h0,4'h0,8'h00); cyc();
        drive(0,0,0,1, 4'h0,4'h0,8'h00); cyc();
        chk("cl_state_closed", 32'(state), 32'd3);
        chk("cl_grant", 32'(booth_grant), 32'h1);
        chk("cl_locked", 32'(booth_locked), 32'h1);
        drive(0,0,0,0, 4'hF,4'h0,8'h00); cyc();
        chk("cl_req_ignored", 32'(tally_valid), 32'd0);
        drive(0,1,0,0, 4'h0,4'h0,8'h00); cyc();
        chk("cl_reopen_state", 32'(state), 32'd1);
        chk("cl_reopen_locks", 32'(booth_locked), 32'd0);

        // Randomized traffic against the model
        drive(1,0,0,0, 4'h0,4'h0,8'h00); cyc();
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            session_open  = ($urandom_range(0, 9) == 0);
            session_close = ($urandom_range(0, 24) == 0);
            booth_req     = 4'($urandom);
            booth_choice  = 8'($urandom);
            booth_rearm   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tally_ack     = (n < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cyc();
            chk("rnd_state", 32'(state), 32'(m_state));
            chk("rnd_valid", 32'(tally_valid), 32'(m_valid));
            chk("rnd_grant", 32'(booth_grant), 32'(m_grant));
            chk("rnd_locked", 32'(booth_locked), 32'(m_locked));
            chk("rnd_terr", 32'(timeout_err), 32'(m_terr));
            chk("rnd_grant_onehot", 32'($countones(booth_grant) <= 1), 32'd1);
            if (m_valid) begin
                chk("rnd_booth", 32'(tally_booth), 32'(m_booth));
                chk("rnd_cand", 32'(tally_candidate), 32'(m_cand));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
